// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback data, commits it,
// serves two bypassed read ports and keeps last-write / write-count observability registers.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] ALU_Res_i,
    input  logic [DATA_W-1:0] Read_Data_i,
    input  logic [ADDR_W-1:0] RdAddr_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic [ADDR_W-1:0] RsAddr_i,
    input  logic [ADDR_W-1:0] RtAddr_i,
    output logic [DATA_W-1:0] RsData_o,
    output logic [DATA_W-1:0] RtData_o,
    output logic [DATA_W-1:0] WbData_o,
    output logic [ADDR_W-1:0] WbLastAddr_o,
    output logic [DATA_W-1:0] WbLastData_o,
    output logic [CNT_W-1:0]  WbCount_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] wb_data;
    logic              we;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic [CNT_W-1:0]  wb_count;

    assign wb_data = MemToReg_i ? Read_Data_i : ALU_Res_i;

    // Gating with rst_i keeps the bypass path quiet while reset holds the file at zero.
    assign we = RegWrite_i && (RdAddr_i != '0) && rst_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[RdAddr_i] <= wb_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_addr <= '0;
            last_data <= '0;
            wb_count  <= '0;
        end else if (we) begin
            last_addr <= RdAddr_i;
            last_data <= wb_data;
            wb_count  <= wb_count + CNT_W'(1);
        end
    end

    // Write-first bypass: a write presented this cycle is seen by the ID stage immediately.
    always_comb begin
        rs_data = '0;
        if (RsAddr_i == '0) begin
            rs_data = '0;
        end else if (we && (RsAddr_i == RdAddr_i)) begin
            rs_data = wb_data;
        end else begin
            rs_data = regs[RsAddr_i];
        end
    end

    always_comb begin
        rt_data = '0;
        if (RtAddr_i == '0) begin
            rt_data = '0;
        end else if (we && (RtAddr_i == RdAddr_i)) begin
            rt_data = wb_data;
        end else begin
            rt_data = regs[RtAddr_i];
        end
    end

    assign RsData_o     = rs_data;
    assign RtData_o     = rt_data;
    assign WbData_o     = wb_data;
    assign WbLastAddr_o = last_addr;
    assign WbLastData_o = last_data;
    assign WbCount_o    = wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomised checks of wb_regfile; a second instance with a 4-bit counter
// shares all inputs so the counter wrap can be observed.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res;
    logic [31:0] read_data;
    logic [4:0]  rd_addr;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic [31:0] wb_count;

    logic [31:0] small_rs_data;
    logic [31:0] small_rt_data;
    logic [31:0] small_wb_data;
    logic [4:0]  small_last_addr;
    logic [31:0] small_last_data;
    logic [3:0]  small_count;

    int test_count;
    int fail_count;

    logic [31:0] model_regs [32];
    logic [31:0] model_count;
    logic [4:0]  model_last_addr;
    logic [31:0] model_last_data;

    wb_regfile dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ALU_Res_i    (alu_res),
        .Read_Data_i  (read_data),
        .RdAddr_i     (rd_addr),
        .MemToReg_i   (mem_to_reg),
        .RegWrite_i   (reg_write),
        .RsAddr_i     (rs_addr),
        .RtAddr_i     (rt_addr),
        .RsData_o     (rs_data),
        .RtData_o     (rt_data),
        .WbData_o     (wb_data),
        .WbLastAddr_o (last_addr),
        .WbLastData_o (last_data),
        .WbCount_o    (wb_count)
    );

    wb_regfile #(.CNT_W(4)) dut_small (
        .clk_i        (clk),
        .rst_i        (rst),
        .ALU_Res_i    (alu_res),
        .Read_Data_i  (read_data),
        .RdAddr_i     (rd_addr),
        .MemToReg_i   (mem_to_reg),
        .RegWrite_i   (reg_write),
        .RsAddr_i     (rs_addr),
        .RtAddr_i     (rt_addr),
        .RsData_o     (small_rs_data),
        .RtData_o     (small_rt_data),
        .WbData_o     (small_wb_data),
        .WbLastAddr_o (small_last_addr),
        .WbLastData_o (small_last_data),
        .WbCount_o    (small_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic m, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [4:0] rs, input logic [4:0] rt);
        reg_write  = w;
        mem_to_reg = m;
        rd_addr    = rd;
        alu_res    = alu;
        read_data  = rdata;
        rs_addr    = rs;
        rt_addr    = rt;
        #1;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_count     = 32'h0;
        model_last_addr = 5'h0;
        model_last_data = 32'h0;
    endtask

    // Advances one rising edge with inputs held, then updates the reference model.
    task automatic clockEdge();
        logic        model_we;
        logic [31:0] model_wb;
        model_we = reg_write && (rd_addr != 5'd0) && rst;
        model_wb = mem_to_reg ? read_data : alu_res;
        @(posedge clk);
        #1;
        if (model_we) begin
            model_regs[rd_addr] = model_wb;
            model_count         = model_count + 32'd1;
            model_last_addr     = rd_addr;
            model_last_data     = model_wb;
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] idx);
        logic model_we;
        model_we = reg_write && (rd_addr != 5'd0) && rst;
        if (idx == 5'd0) return 32'h0;
        if (model_we && idx == rd_addr) return mem_to_reg ? read_data : alu_res;
        return model_regs[idx];
    endfunction

    initial begin
        test_count = 0;
        fail_count = 0;
        resetModel();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
        #2;
        checkOutput("reset_rs", rs_data, 32'h0);
        checkOutput("reset_rt", rt_data, 32'h0);
        checkOutput("reset_count", wb_count, 32'h0);
        checkOutput("reset_last_addr", {27'h0, last_addr}, 32'h0);
        checkOutput("reset_last_data", last_data, 32'h0);
        #9;
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 5'd0, 5'd0);
        checkOutput("alu_wbdata", wb_data, 32'h1234_5678);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd0);
        checkOutput("alu_write_r5", rs_data, 32'h1234_5678);
        checkOutput("alu_write_count", wb_count, 32'd1);
        checkOutput("alu_write_last_addr", {27'h0, last_addr}, 32'd5);
        checkOutput("alu_write_last_data", last_data, 32'h1234_5678);

        applyStimulus(1'b1, 1'b1, 5'd5, 32'h0000_0001, 32'hDEAD_BEEF, 5'd0, 5'd0);
        checkOutput("load_wbdata", wb_data, 32'hDEAD_BEEF);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd0, 5'd5);
        checkOutput("load_write_r5", rt_data, 32'hDEAD_BEEF);
        checkOutput("load_write_count", wb_count, 32'd2);

        applyStimulus(1'b1, 1'b0, 5'd7, 32'h11, 32'h0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h22, 32'h0, 5'd7, 5'd7);
        checkOutput("bypass_rs", rs_data, 32'h22);
        checkOutput("bypass_rt", rt_data, 32'h22);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd7, 32'h33, 32'h0, 5'd7, 5'd7);
        checkOutput("after_bypass_rs", rs_data, 32'h22);
        checkOutput("after_bypass_rt", rt_data, 32'h22);
        checkOutput("after_bypass_count", wb_count, 32'd4);

        applyStimulus(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
        checkOutput("x0_same_cycle", rs_data, 32'h0);
        checkOutput("x0_wbdata", wb_data, 32'hFFFF_FFFF);
        clockEdge();
        checkOutput("x0_next_cycle", rs_data, 32'h0);
        checkOutput("x0_count", wb_count, 32'd4);
        checkOutput("x0_last_addr", {27'h0, last_addr}, 32'd7);
        checkOutput("x0_last_data", last_data, 32'h22);

        applyStimulus(1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd9, 32'hAA, 32'h0, 5'd9, 5'd9);
        checkOutput("disabled_no_bypass", rs_data, 32'h99);
        checkOutput("disabled_wbdata", wb_data, 32'hAA);
        clockEdge();
        checkOutput("disabled_r9_kept", rt_data, 32'h99);
        checkOutput("disabled_count", wb_count, 32'd5);

        applyStimulus(1'b1, 1'b0, 5'd3, 32'h5555, 32'h0, 5'd5, 5'd7);
        #2;
        rst = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset_rs", rs_data, 32'h0);
        checkOutput("midreset_rt", rt_data, 32'h0);
        checkOutput("midreset_count", wb_count, 32'h0);
        checkOutput("midreset_last_addr", {27'h0, last_addr}, 32'h0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 5'd3, 32'h5555, 32'h0, 5'd3, 5'd3);
        checkOutput("midreset_r3_dropped", rs_data, 32'h0);
        rst = 1'b1;
        #1;
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(32 - i));
            checkOutput($sformatf("cleared_rs_r%0d", i), rs_data, 32'h0);
            checkOutput($sformatf("cleared_rt_r%0d", 32 - i), rt_data, 32'h0);
        end
        checkOutput("cleared_r3_count", wb_count, 32'h0);

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 5'(i), 32'h100 + 32'(i), 32'h0, 5'd0, 5'd0);
            clockEdge();
            if (i == 15) checkOutput("wrap_small_15", {28'h0, small_count}, 32'd15);
        end
        checkOutput("wrap_small_count", {28'h0, small_count}, 32'd0);
        checkOutput("wrap_main_count", wb_count, 32'd16);
        checkOutput("wrap_last_addr", {27'h0, last_addr}, 32'd16);
        checkOutput("wrap_last_data", last_data, 32'h110);

        for (int i = 0; i < 1000; i++) begin
            logic [4:0] rd;
            logic [4:0] rs;
            logic [4:0] rt;
            rd = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
                          $urandom, $urandom, rs, rt);
            checkOutput($sformatf("rand%0d_rs", i), rs_data, modelRead(rs));
            checkOutput($sformatf("rand%0d_rt", i), rt_data, modelRead(rt));
            checkOutput($sformatf("rand%0d_wbdata", i), wb_data, mem_to_reg ? read_data : alu_res);
            clockEdge();
            checkOutput($sformatf("rand%0d_count", i), wb_count, model_count);
            checkOutput($sformatf("rand%0d_small_count", i), {28'h0, small_count}, {28'h0, model_count[3:0]});
            checkOutput($sformatf("rand%0d_last_addr", i), {27'h0, last_addr}, {27'h0, model_last_addr});
            checkOutput($sformatf("rand%0d_last_data", i), last_data, model_last_data);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
